// File: rtl/lock_sequencer.sv
// Front-end sequencer for the serial lock pattern detector: collects an entered
// code, replays it into the detector, then decides between unlock and failure.
module lock_sequencer #(
    parameter int unsigned CODE_LEN       = 4,
    parameter int unsigned MAX_ATTEMPTS   = 3,
    parameter int unsigned UNLOCK_CYCLES  = 16,
    parameter int unsigned LOCKOUT_CYCLES = 64,
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              bit_valid,
    input  logic                              bit_in,
    input  logic                              det_match,
    output logic                              det_clr,
    output logic                              det_din,
    output logic                              unlock,
    output logic                              alarm,
    output logic                              busy,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0] fail_cnt
);

    localparam int unsigned FW      = $clog2(MAX_ATTEMPTS + 1);
    localparam int unsigned MAX_A   = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned MAX_B   = (TIMEOUT_CYCLES > CODE_LEN) ? TIMEOUT_CYCLES : CODE_LEN;
    localparam int unsigned MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CW      = $clog2(MAX_CNT + 1);
    localparam int unsigned IW      = $clog2(CODE_LEN);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ENTRY    = 3'd1;
    localparam logic [2:0] S_CLEAR    = 3'd2;
    localparam logic [2:0] S_STREAM   = 3'd3;
    localparam logic [2:0] S_CHECK    = 3'd4;
    localparam logic [2:0] S_UNLOCKED = 3'd5;
    localparam logic [2:0] S_LOCKOUT  = 3'd6;

    logic [2:0]          state, state_n;
    logic [CODE_LEN-1:0] buffer, buffer_n;
    logic [CW-1:0]       bit_cnt, bit_cnt_n;
    logic [CW-1:0]       idx, idx_n;
    logic [CW-1:0]       timer, timer_n;
    logic [FW-1:0]       fail_n;
    logic                det_clr_n, det_din_n, unlock_n, alarm_n, busy_n;

    // Next-state, datapath and next-output decode
    always_comb begin
        state_n   = state;
        buffer_n  = buffer;
        bit_cnt_n = bit_cnt;
        idx_n     = idx;
        timer_n   = timer;
        fail_n    = fail_cnt;

        case (state)
            S_IDLE: begin
                if (bit_valid) begin
                    buffer_n[0] = bit_in;
                    bit_cnt_n   = CW'(1);
                    timer_n     = '0;
                    state_n     = (CODE_LEN == 1) ? S_CLEAR : S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (bit_valid) begin
                    // A bit arriving on the expiry edge still wins over the timeout
                    buffer_n[IW'(bit_cnt)] = bit_in;
                    bit_cnt_n              = bit_cnt + CW'(1);
                    timer_n                = '0;
                    if (bit_cnt == CW'(CODE_LEN - 1)) begin
                        state_n = S_CLEAR;
                    end
                end else if (timer >= CW'(TIMEOUT_CYCLES - 1)) begin
                    state_n   = S_IDLE;
                    timer_n   = '0;
                    bit_cnt_n = '0;
                end else begin
                    timer_n = timer + CW'(1);
                end
            end
            S_CLEAR: begin
                idx_n     = '0;
                bit_cnt_n = '0;
                state_n   = S_STREAM;
            end
            S_STREAM: begin
                if (idx == CW'(CODE_LEN - 1)) begin
                    idx_n   = '0;
                    state_n = S_CHECK;
                end else begin
                    idx_n = idx + CW'(1);
                end
            end
            S_CHECK: begin
                timer_n = '0;
                if (det_match) begin
                    fail_n  = '0;
                    state_n = S_UNLOCKED;
                end else begin
                    if (fail_cnt < FW'(MAX_ATTEMPTS)) begin
                        fail_n = fail_cnt + FW'(1);
                    end
                    state_n = (fail_n == FW'(MAX_ATTEMPTS)) ? S_LOCKOUT : S_IDLE;
                end
            end
            S_UNLOCKED: begin
                if (timer >= CW'(UNLOCK_CYCLES - 1)) begin
                    timer_n = '0;
                    state_n = S_IDLE;
                end else begin
                    timer_n = timer + CW'(1);
                end
            end
            S_LOCKOUT: begin
                if (timer >= CW'(LOCKOUT_CYCLES - 1)) begin
                    timer_n = '0;
                    fail_n  = '0;
                    state_n = S_IDLE;
                end else begin
                    timer_n = timer + CW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Outputs follow the next state so the registered copies line up with it
        det_clr_n = (state_n == S_CLEAR);
        det_din_n = (state_n == S_STREAM) ? buffer_n[IW'(idx_n)] : 1'b0;
        unlock_n  = (state_n == S_UNLOCKED);
        alarm_n   = (state_n == S_LOCKOUT);
        busy_n    = (state_n != S_IDLE) && (state_n != S_ENTRY);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            buffer   <= '0;
            bit_cnt  <= '0;
            idx      <= '0;
            timer    <= '0;
            fail_cnt <= '0;
            det_clr  <= 1'b0;
            det_din  <= 1'b0;
            unlock   <= 1'b0;
            alarm    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            buffer   <= buffer_n;
            bit_cnt  <= bit_cnt_n;
            idx      <= idx_n;
            timer    <= timer_n;
            fail_cnt <= fail_n;
            det_clr  <= det_clr_n;
            det_din  <= det_din_n;
            unlock   <= unlock_n;
            alarm    <= alarm_n;
            busy     <= busy_n;
        end
    end

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench for lock_sequencer with a behavioural "1011" serial detector.
module tb_lock_sequencer;

    logic       clk;
    logic       reset_n;
    logic       bit_valid;
    logic       bit_in;
    logic       det_match;
    logic       det_clr;
    logic       det_din;
    logic       unlock;
    logic       alarm;
    logic       busy;
    logic [1:0] fail_cnt;

    int errors = 0;
    int checks = 0;

    localparam logic [3:0] PATTERN = 4'b1011;

    lock_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .det_match (det_match),
        .det_clr   (det_clr),
        .det_din   (det_din),
        .unlock    (unlock),
        .alarm     (alarm),
        .busy      (busy),
        .fail_cnt  (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Detector: shift register of the last four bits since its clear
    logic [3:0] det_hist;
    logic [2:0] det_fill;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            det_hist <= 4'b0;
            det_fill <= 3'd0;
        end else if (det_clr) begin
            det_hist <= 4'b0;
            det_fill <= 3'd0;
        end else begin
            det_hist <= {det_hist[2:0], det_din};
            if (det_fill < 3'd4) det_fill <= det_fill + 3'd1;
        end
    end
    assign det_match = (det_fill == 3'd4) && (det_hist == PATTERN);

    // Drives n bits MSB-first, one per edge; returns on the negedge after the last edge
    task automatic drive_bits(input logic [3:0] bits, input int n);
        logic [3:0] sh;
        sh = bits << (4 - n);
        for (int i = 0; i < n; i++) begin
            bit_valid = 1'b1;
            bit_in    = sh[3];
            sh        = sh << 1;
            @(negedge clk);
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic idle(input int n);
        bit_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Called in the CLEAR cycle; returns in the cycle after CHECK
    task automatic check_stream(input logic [3:0] code, input logic exp_unlock, input logic exp_alarm);
        logic [3:0] sh;
        sh = code;
        checks++;
        if (det_clr !== 1'b1 || det_din !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_cycle code=%b: clr=%b din=%b busy=%b expected 1 0 1", code, det_clr, det_din, busy);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (det_din !== sh[3] || det_clr !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stream_bit%0d code=%b: din=%b clr=%b busy=%b expected %b 0 1", k, code, det_din, det_clr, busy, sh[3]);
            end
            sh = sh << 1;
        end
        @(negedge clk);
        checks++;
        if (det_din !== 1'b0 || unlock !== 1'b0 || alarm !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL check_cycle code=%b: din=%b unlock=%b alarm=%b busy=%b expected 0 0 0 1", code, det_din, unlock, alarm, busy);
        end
        @(negedge clk);
        checks++;
        if (unlock !== exp_unlock || alarm !== exp_alarm) begin
            errors++;
            $display("FAIL decision code=%b: unlock=%b alarm=%b expected %b %b", code, unlock, alarm, exp_unlock, exp_alarm);
        end
    endtask

    task automatic run_attempt(input logic [3:0] code, input logic exp_unlock, input logic exp_alarm);
        drive_bits(code, 4);
        check_stream(code, exp_unlock, exp_alarm);
    endtask

    // Counts high cycles of unlock or alarm, optionally toggling bit_valid meanwhile
    task automatic measure(input logic use_alarm, input logic poke, output int n);
        n = 0;
        while (((use_alarm ? alarm : unlock) === 1'b1) && n < 200) begin
            n++;
            if (poke) begin
                bit_valid = n[0];
                bit_in    = 1'b1;
            end
            @(negedge clk);
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({det_clr, det_din, unlock, alarm, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: clr/din/unlock/alarm/busy=%b expected 00000", {det_clr, det_din, unlock, alarm, busy});
        end
        checks++;
        if (fail_cnt !== 2'd0) begin
            errors++;
            $display("FAIL reset_fail_cnt: got %0d expected 0", fail_cnt);
        end
        reset_n = 1'b1;
        idle(2);
        checks++;
        if (busy !== 1'b0 || unlock !== 1'b0 || alarm !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: busy=%b unlock=%b alarm=%b expected 0 0 0", busy, unlock, alarm);
        end
    endtask

    task automatic test_unlock();
        int n;
        run_attempt(4'b1011, 1'b1, 1'b0);
        checks++;
        if (fail_cnt !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL unlock_state: fail_cnt=%0d busy=%b expected 0 1", fail_cnt, busy);
        end
        measure(1'b0, 1'b0, n);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL unlock_width: got %0d cycles expected 16", n);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL unlock_exit_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_wrong();
        run_attempt(4'b1111, 1'b0, 1'b0);
        checks++;
        if (fail_cnt !== 2'd1 || busy !== 1'b0 || alarm !== 1'b0 || unlock !== 1'b0) begin
            errors++;
            $display("FAIL wrong_code: fail_cnt=%0d busy=%b alarm=%b unlock=%b expected 1 0 0 0", fail_cnt, busy, alarm, unlock);
        end
    endtask

    task automatic test_lockout();
        int n;
        do_reset();
        run_attempt(4'b1111, 1'b0, 1'b0);
        checks++;
        if (fail_cnt !== 2'd1) begin
            errors++;
            $display("FAIL lockout_fail1: got %0d expected 1", fail_cnt);
        end
        run_attempt(4'b0000, 1'b0, 1'b0);
        checks++;
        if (fail_cnt !== 2'd2) begin
            errors++;
            $display("FAIL lockout_fail2: got %0d expected 2", fail_cnt);
        end
        run_attempt(4'b1010, 1'b0, 1'b1);
        checks++;
        if (fail_cnt !== 2'd3 || busy !== 1'b1 || unlock !== 1'b0) begin
            errors++;
            $display("FAIL lockout_entry: fail_cnt=%0d busy=%b unlock=%b expected 3 1 0", fail_cnt, busy, unlock);
        end
        measure(1'b1, 1'b1, n);
        checks++;
        if (n != 64) begin
            errors++;
            $display("FAIL alarm_width: got %0d cycles expected 64", n);
        end
        checks++;
        if (fail_cnt !== 2'd0 || busy !== 1'b0 || alarm !== 1'b0) begin
            errors++;
            $display("FAIL lockout_exit: fail_cnt=%0d busy=%b alarm=%b expected 0 0 0", fail_cnt, busy, alarm);
        end
    endtask

    task automatic test_timeout();
        int n;
        run_attempt(4'b1111, 1'b0, 1'b0);
        // Partial "10" followed by exactly 32 idle edges is discarded
        drive_bits(4'b0010, 2);
        idle(32);
        checks++;
        if (fail_cnt !== 2'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_discard: fail_cnt=%0d busy=%b expected 1 0", fail_cnt, busy);
        end
        run_attempt(4'b1011, 1'b1, 1'b0);
        checks++;
        if (fail_cnt !== 2'd0) begin
            errors++;
            $display("FAIL timeout_fresh_unlock: fail_cnt=%0d expected 0", fail_cnt);
        end
        measure(1'b0, 1'b0, n);
        // Partial "10", 31 idle edges, then "11" lands on the expiry edge and completes 1011
        drive_bits(4'b0010, 2);
        idle(31);
        drive_bits(4'b0011, 2);
        check_stream(4'b1011, 1'b1, 1'b0);
        measure(1'b0, 1'b0, n);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL timeout_edge_unlock_width: got %0d expected 16", n);
        end
    endtask

    task automatic test_two_fail_then_unlock();
        int n;
        run_attempt(4'b0111, 1'b0, 1'b0);
        run_attempt(4'b1101, 1'b0, 1'b0);
        checks++;
        if (fail_cnt !== 2'd2) begin
            errors++;
            $display("FAIL two_fail_cnt: got %0d expected 2", fail_cnt);
        end
        run_attempt(4'b1011, 1'b1, 1'b0);
        checks++;
        if (fail_cnt !== 2'd0) begin
            errors++;
            $display("FAIL unlock_clears_fail: got %0d expected 0", fail_cnt);
        end
        measure(1'b0, 1'b0, n);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL two_fail_unlock_width: got %0d expected 16", n);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        run_attempt(4'b0000, 1'b0, 1'b0);
        drive_bits(4'b1011, 4);
        @(negedge clk);
        checks++;
        if (det_din !== 1'b1 || fail_cnt !== 2'd1) begin
            errors++;
            $display("FAIL mid_stream_pre: din=%b fail_cnt=%0d expected 1 1", det_din, fail_cnt);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({det_clr, det_din, unlock, alarm, busy} !== 5'b0 || fail_cnt !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: clr/din/unlock/alarm/busy=%b fail_cnt=%0d expected 00000 0",
                     {det_clr, det_din, unlock, alarm, busy}, fail_cnt);
        end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (unlock !== 1'b0 || alarm !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL post_abort_quiet: activity=%b expected 0", seen);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        test_reset();
        test_unlock();
        test_wrong();
        test_lockout();
        test_timeout();
        test_two_fail_then_unlock();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lock_sequencer.md
Name: lock_sequencer

Overview:
Front-end controller for the serial lock pattern detector. It collects a user-entered code one bit at a time, clears the detector, and replays the buffered bits into it one bit per clock. It then samples the detector's match output and decides between unlock and failure. It also counts failed attempts, enforces an alarm lockout, and discards partial entries that time out.

Parameters:
CODE_LEN, 4, number of code bits per attempt (2..16)
MAX_ATTEMPTS, 3, consecutive failures that trigger lockout (1..15)
UNLOCK_CYCLES, 16, clocks unlock stays high
LOCKOUT_CYCLES, 64, clocks alarm stays high
TIMEOUT_CYCLES, 32, max idle clocks between entry bits before the partial entry is discarded

Ports:
clk  in  1  single system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
bit_valid  in  1  entry strobe; bit_in is accepted on a clk edge with bit_valid=1 in IDLE/ENTRY
bit_in  in  1  entry code bit
det_match  in  1  detector pattern_detect output
det_clr  out  1  active-high clear to the detector reset pin
det_din  out  1  serial bit driven to the detector din
unlock  out  1  lock-open pulse
alarm  out  1  lockout indicator
busy  out  1  1 when entry bits are being ignored (all states except IDLE/ENTRY)
fail_cnt  out  $clog2(MAX_ATTEMPTS+1)  consecutive failed attempts

Behaviour:
- States: IDLE, ENTRY, CLEAR, STREAM, CHECK, UNLOCKED, LOCKOUT. All outputs are Moore-decoded from registered state and counters.
- Reset (reset_n=0, asynchronous): state=IDLE; buffer, bit_cnt, timer and fail_cnt=0. Outputs: det_clr=0, det_din=0, unlock=0, alarm=0, busy=0, fail_cnt=0.
- IDLE: bit_valid=1 stores bit_in into buffer slot 0, sets bit_cnt=1 and goes to ENTRY. If CODE_LEN would be reached by that bit, go straight to CLEAR.
- ENTRY:
  - each accepted bit is stored at slot bit_cnt, then bit_cnt increments and timer clears.
  - the bit making bit_cnt==CODE_LEN moves the state to CLEAR.
  - when there is no bit_valid, timer increments. When timer reaches TIMEOUT_CYCLES, the entry is discarded and the state returns to IDLE; fail_cnt is unchanged.
- CLEAR: one cycle with det_clr=1 and det_din=0, then go to STREAM with idx=0.
- STREAM: CODE_LEN cycles. det_din=buffer[idx] (first-entered bit first) and idx increments each cycle. After the last bit, go to CHECK.
- CHECK: one cycle with det_din=0; det_match is sampled at the end of this cycle.
  - match=1: go to UNLOCKED and clear fail_cnt.
  - match=0: fail_cnt increments (saturating at MAX_ATTEMPTS). If the new value equals MAX_ATTEMPTS, go to LOCKOUT; otherwise go to IDLE.
- UNLOCKED: unlock=1 for exactly UNLOCK_CYCLES cycles, then go to IDLE.
- LOCKOUT: alarm=1 for exactly LOCKOUT_CYCLES cycles. On exit, fail_cnt is cleared and the state goes to IDLE.
- Latency: if the final bit is accepted at edge E, CLEAR occupies [E,E+1), STREAM [E+1,E+1+CODE_LEN), and CHECK the next cycle. unlock or alarm rises at edge E+2+CODE_LEN.
- bit_valid in CLEAR, STREAM, CHECK, UNLOCKED or LOCKOUT is ignored (no buffering, no side effects).
- bit_valid on the same edge the timeout expires: the bit is accepted and the timeout is cancelled.
- Timer and idx widths cover the largest count parameter; all counters saturate and never wrap.
- reset_n asserted mid-attempt or mid-lockout aborts immediately to the reset state, including clearing fail_cnt.

Test Plan:
- Reset then bits 1,0,1,1 on 4 consecutive edges, detector model matches "1011" -> det_clr high 1 cycle, det_din shows 1,0,1,1, unlock high at E+6 for 16 cycles, fail_cnt=0.
- Bits 1,1,1,1 -> no match, fail_cnt=1, busy returns to 0, unlock and alarm stay 0.
- Three consecutive wrong codes -> fail_cnt=3, alarm high 64 cycles, bit_valid pulses during alarm ignored, then fail_cnt=0 and state IDLE.
- Two bits entered then 32 idle cycles -> entry discarded, fail_cnt unchanged. A fresh 1011 then unlocks normally.
- Two failures, then the correct code -> unlock pulses and fail_cnt clears to 0.
- reset_n pulsed low during STREAM -> all outputs 0 asynchronously, det_din=0, no unlock or alarm afterwards.
